// File: rtl/reconf_trigger_pkg.sv
// Shared constants for the reconfiguration trigger: default timing values and
// the one-hot FSM state encoding.
package reconf_trigger_pkg;

  localparam int unsigned DefDebCycles   = 500000;
  localparam int unsigned DefHoldCycles  = 50000000;
  localparam int unsigned DefPulseCycles = 16;
  localparam int unsigned DefBlinkBit    = 23;

  localparam int unsigned NumStates = 5;

  typedef enum logic [NumStates-1:0] {
    StIdle    = 5'b00001,
    StArming  = 5'b00010,
    StWaitRel = 5'b00100,
    StFire    = 5'b01000,
    StLock    = 5'b10000
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output follows the
// synchronized input only after DEB_CYCLES consecutive disagreeing samples.
module sync_debounce
  import reconf_trigger_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DefDebCycles,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      dout  <= RST_VAL;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CntLast) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/reconf_trigger.sv
// Pushbutton-driven remote reconfiguration trigger: hold to arm, release to fire
// a single fixed-width request, then lock until reset.
module reconf_trigger
  import reconf_trigger_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DefDebCycles,
  parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
  parameter int unsigned PULSE_CYCLES = DefPulseCycles,
  parameter int unsigned BLINK_BIT    = DefBlinkBit
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_btn_n,
  input  logic i_sw_sel,
  output logic o_reconf_en,
  output logic o_conf_sel,
  output logic o_led_armed,
  output logic o_busy
);

  localparam int unsigned MaxParam = max3(DEB_CYCLES, HOLD_CYCLES, PULSE_CYCLES);
  localparam int unsigned CntW     = (MaxParam > 1) ? $clog2(MaxParam) : 1;
  localparam int unsigned BlinkIdx = (BLINK_BIT < CntW) ? BLINK_BIT : CntW - 1;

  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax    = '1;

  logic            btn_db;
  logic            sw_db;
  logic            sw_prev;
  state_e          state;
  logic [CntW-1:0] hold_cnt;
  logic [CntW-1:0] hold_inc;
  logic [CntW-1:0] pulse_cnt;

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .RST_VAL    (1'b1)
  ) u_btn_deb (
    .clk  (i_clk),
    .rstn (i_rstn),
    .din  (i_btn_n),
    .dout (btn_db)
  );

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .RST_VAL    (1'b0)
  ) u_sw_deb (
    .clk  (i_clk),
    .rstn (i_rstn),
    .din  (i_sw_sel),
    .dout (sw_db)
  );

  always_comb begin
    hold_inc = (hold_cnt == CntMax) ? hold_cnt : hold_cnt + CntW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= StIdle;
      hold_cnt    <= '0;
      pulse_cnt   <= '0;
      sw_prev     <= 1'b0;
      o_reconf_en <= 1'b0;
      o_conf_sel  <= 1'b0;
      o_led_armed <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      sw_prev <= sw_db;
      unique case (state)
        StIdle: begin
          if (!btn_db) begin
            state       <= StArming;
            hold_cnt    <= '0;
            o_busy      <= 1'b1;
            o_led_armed <= 1'b0;
          end
        end
        StArming: begin
          if (btn_db) begin
            state       <= StIdle;
            hold_cnt    <= '0;
            o_busy      <= 1'b0;
            o_led_armed <= 1'b0;
          end else if (sw_db != sw_prev) begin
            // A new image choice must be held for the full time on its own.
            hold_cnt    <= '0;
            o_led_armed <= 1'b0;
          end else if (hold_inc >= HoldLast) begin
            state       <= StWaitRel;
            hold_cnt    <= hold_inc;
            o_conf_sel  <= sw_db;
            o_led_armed <= 1'b1;
          end else begin
            hold_cnt    <= hold_inc;
            o_led_armed <= hold_inc[BlinkIdx];
          end
        end
        StWaitRel: begin
          if (btn_db) begin
            state       <= StFire;
            pulse_cnt   <= '0;
            o_reconf_en <= 1'b1;
          end
        end
        StFire: begin
          if (pulse_cnt >= PulseLast) begin
            state       <= StLock;
            o_reconf_en <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + CntW'(1);
          end
        end
        StLock: begin
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reconf_trigger.sv
// Directed bench for reconf_trigger with a cycle-level reference model of the
// documented timing rules, plus hand-computed scenario expectations.
module tb_reconf_trigger;

  localparam int Deb   = 4;
  localparam int Hold  = 20;
  localparam int Pulse = 3;
  localparam int Blink = 2;
  // Counter width is $clog2(20) = 5 bits, so counters saturate at 31.
  localparam int CntTop = 31;

  logic clk = 1'b0;
  logic rstn;
  logic btn_n;
  logic sw_sel;
  logic o_reconf_en;
  logic o_conf_sel;
  logic o_led_armed;
  logic o_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reconf_trigger #(
    .DEB_CYCLES   (Deb),
    .HOLD_CYCLES  (Hold),
    .PULSE_CYCLES (Pulse),
    .BLINK_BIT    (Blink)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_btn_n     (btn_n),
    .i_sw_sel    (sw_sel),
    .o_reconf_en (o_reconf_en),
    .o_conf_sel  (o_conf_sel),
    .o_led_armed (o_led_armed),
    .o_busy      (o_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phases: 0 idle, 1 arming, 2 waiting release, 3 firing, 4 locked.
  bit m_bp0, m_bp1, m_bdb;
  bit m_sp0, m_sp1, m_sdb;
  int m_brun, m_srun;
  int m_phase, m_hold, m_fire;
  bit m_sel, m_prev_sw;

  function automatic int sat_inc(input int v);
    return (v >= CntTop) ? CntTop : v + 1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_bp0 <= 1'b1; m_bp1 <= 1'b1; m_bdb <= 1'b1; m_brun <= 0;
      m_sp0 <= 1'b0; m_sp1 <= 1'b0; m_sdb <= 1'b0; m_srun <= 0;
      m_phase <= 0; m_hold <= 0; m_fire <= 0; m_sel <= 1'b0; m_prev_sw <= 1'b0;
    end else begin
      m_bp0 <= btn_n;
      m_bp1 <= m_bp0;
      if (m_bp1 == m_bdb) m_brun <= 0;
      else if (m_brun + 1 == Deb) begin m_bdb <= m_bp1; m_brun <= 0; end
      else m_brun <= m_brun + 1;
      m_sp0 <= sw_sel;
      m_sp1 <= m_sp0;
      if (m_sp1 == m_sdb) m_srun <= 0;
      else if (m_srun + 1 == Deb) begin m_sdb <= m_sp1; m_srun <= 0; end
      else m_srun <= m_srun + 1;
      m_prev_sw <= m_sdb;
      case (m_phase)
        0: if (!m_bdb) begin m_phase <= 1; m_hold <= 0; end
        1: begin
          if (m_bdb) m_phase <= 0;
          else if (m_sdb != m_prev_sw) m_hold <= 0;
          else begin
            m_hold <= sat_inc(m_hold);
            if (sat_inc(m_hold) >= Hold - 1) begin m_phase <= 2; m_sel <= m_sdb; end
          end
        end
        2: if (m_bdb) begin m_phase <= 3; m_fire <= 1; end
        3: if (m_fire >= Pulse) m_phase <= 4; else m_fire <= m_fire + 1;
        default: m_phase <= 4;
      endcase
    end
  end

  int exp_led;
  always_comb begin
    exp_led = 0;
    if (m_phase == 1) exp_led = (m_hold >> Blink) & 1;
    else if (m_phase >= 2) exp_led = 1;
  end

  always @(negedge clk) begin
    check("cyc_reconf_en", int'(o_reconf_en), int'(m_phase == 3));
    check("cyc_conf_sel", int'(o_conf_sel), int'(m_sel));
    check("cyc_led_armed", int'(o_led_armed), exp_led);
    check("cyc_busy", int'(o_busy), int'(m_phase != 0));
  end

  // Pulse monitor.
  bit en_prev = 1'b0;
  int pulses = 0, cur_w = 0, last_w = 0, sel_at_pulse = 0;
  always @(negedge clk) begin
    en_prev <= o_reconf_en;
    if (o_reconf_en && !en_prev) begin
      pulses <= pulses + 1;
      sel_at_pulse <= int'(o_conf_sel);
      cur_w <= 1;
    end else if (o_reconf_en) begin
      cur_w <= cur_w + 1;
    end
    if (!o_reconf_en && en_prev) last_w <= cur_w;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  int base;

  initial begin
    rstn = 1'b0; btn_n = 1'b1; sw_sel = 1'b0;
    tick(3);
    check("rst_reconf_en", int'(o_reconf_en), 0);
    check("rst_conf_sel", int'(o_conf_sel), 0);
    check("rst_led", int'(o_led_armed), 0);
    check("rst_busy", int'(o_busy), 0);
    rstn = 1'b1;

    // Bouncy press, clean 30-cycle hold with sw=1, release.
    sw_sel = 1'b1;
    tick(10);
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0; tick(3);
      btn_n = 1'b1; tick(3);
    end
    check("bounce_ignored_busy", int'(o_busy), 0);
    btn_n = 1'b0; tick(30);
    btn_n = 1'b1; tick(20);
    check("s1_pulse_count", pulses - base, 1);
    check("s1_pulse_width", last_w, Pulse);
    check("s1_sel_at_pulse", sel_at_pulse, 1);
    check("s1_lock_busy", int'(o_busy), 1);
    check("s1_lock_led", int'(o_led_armed), 1);

    // Short press: back to idle, nothing fired.
    do_reset(); sw_sel = 1'b0; tick(8);
    base = pulses;
    btn_n = 1'b0; tick(10);
    check("s2_arming_busy", int'(o_busy), 1);
    btn_n = 1'b1; tick(10);
    check("s2_idle_busy", int'(o_busy), 0);
    check("s2_led_off", int'(o_led_armed), 0);
    check("s2_no_pulse", pulses - base, 0);

    // Switch change debounced at hold count 15 restarts the hold.
    do_reset(); sw_sel = 1'b0; tick(8);
    base = pulses;
    btn_n = 1'b0; tick(16);
    sw_sel = 1'b1; tick(25);
    check("s3_pre_busy", int'(o_busy), 1);
    check("s3_pre_led", int'(o_led_armed), 0);
    check("s3_pre_sel", int'(o_conf_sel), 0);
    tick(1);
    check("s3_waitrel_led", int'(o_led_armed), 1);
    check("s3_latched_sel", int'(o_conf_sel), 1);

    // Switch flipped while waiting for release is ignored.
    sw_sel = 1'b0; tick(12);
    check("s4_sel_held", int'(o_conf_sel), 1);
    btn_n = 1'b1; tick(20);
    check("s4_pulse_count", pulses - base, 1);
    check("s4_pulse_width", last_w, Pulse);
    check("s4_sel_at_pulse", sel_at_pulse, 1);
    check("s4_sel_after", int'(o_conf_sel), 1);

    // Second full press after lock does nothing.
    base = pulses;
    btn_n = 1'b0; tick(30);
    btn_n = 1'b1; tick(20);
    check("s5_no_retrigger", pulses - base, 0);
    check("s5_lock_busy", int'(o_busy), 1);

    // Press already held when reset releases counts as a press.
    btn_n = 1'b0;
    do_reset();
    tick(8);
    check("s7_held_press_busy", int'(o_busy), 1);
    btn_n = 1'b1; tick(10);
    check("s7_release_idle", int'(o_busy), 0);

    // Reset during the second fire cycle, then fire again.
    do_reset(); sw_sel = 1'b1; tick(8);
    btn_n = 1'b0; tick(30);
    btn_n = 1'b1; tick(8);
    check("s6_fire_en", int'(o_reconf_en), 1);
    #2 rstn = 1'b0;
    #1;
    check("s6_async_en", int'(o_reconf_en), 0);
    check("s6_async_busy", int'(o_busy), 0);
    check("s6_async_sel", int'(o_conf_sel), 0);
    tick(2);
    rstn = 1'b1;
    tick(8);
    base = pulses;
    btn_n = 1'b0; tick(30);
    btn_n = 1'b1; tick(20);
    check("s6_refire_count", pulses - base, 1);
    check("s6_refire_width", last_w, Pulse);
    check("s6_refire_sel", int'(o_conf_sel), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
